hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard-control block for the five-stage MIPS pipeline. It tracks in-flight destination registers in the EX, MEM and WB stages and, for the decode-stage instruction, generates stall/bubble requests. It also generates forwarding selects for the EX-stage operands and flush strobes on a taken branch resolved in MEM. It sits beside the Controller and drives the enables/clears of the Fetch_To_Decode, Decode_To_Execute and Execute_To_DataMem pipeline registers, plus the two EX operand muxes.

## Interface

- REG_W, 5, register-address width; register 0 is hard-wired zero
- RF_BYPASS, 1, 1 = register file returns same-cycle write data on read; 0 = ID must not read a register being written in WB
- STALL_CNT_W, 16, width of the stall-cycle counter

- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low; sampled on rising Clk
- id_valid  in  1  decode stage holds a real instruction
- id_rs, id_rt  in  REG_W  decode source register addresses
- id_uses_rs, id_uses_rt  in  1  decode instruction reads rs / rt
- id_rd  in  REG_W  final destination (after RegDst/Jal selection)
- id_reg_write  in  1  decode instruction writes id_rd
- id_is_load  in  1  decode instruction is a load
- branch_taken  in  1  branch/jump redirect resolved in MEM this cycle
- stall  out  1  hold PC and Fetch_To_Decode
- bubble  out  1  load zeros (NOP) into Decode_To_Execute
- flush_ifid, flush_idex, flush_exmem  out  1  synchronous clears for those pipeline registers
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 MEM ALU result, 10 WB write data
- stall_count  out  STALL_CNT_W  saturating count of stall cycles

## Operation

- Three entries EX, MEM, WB, each {valid, rd, reg_write, is_load}; EX also holds rs, rt, uses_rs, uses_rt.
- Entry "writes r" iff valid & reg_write & rd==r & r!=0. Register 0 never creates a hazard or forward.
- Every cycle: WB<=MEM, MEM<=EX, EX<=ID fields (valid=id_valid), except as below.
- Stall cycle: EX<=empty (bubble), MEM/WB still advance.
- branch_taken cycle: flush_ifid=flush_idex=flush_exmem=1; EX<=empty, MEM<=empty, WB<=old MEM; stall=bubble=0. Flush overrides stall.
- Stall condition (FWD_EN defined): id_valid & an ID source used & EX entry writes it & EX.is_load. Also, if RF_BYPASS=0, WB entry writes it.
- Stall condition (FWD_EN undefined): id_valid & an ID source used & EX or MEM entry writes it. Also, if RF_BYPASS=0, WB entry writes it.
- bubble = stall.
- fwd_a (rs; fwd_b identical on rt): EX.valid & EX.uses_rs & MEM writes rs & !MEM.is_load -> 01; else WB writes rs -> 10; else 00. MEM has priority over WB.
- A MEM-stage load matching an EX source is unreachable by construction and is a verification assertion.
- stall_count increments by 1 on each cycle with stall=1, saturating at all-ones.

## Timing

- stall, bubble, flushes: combinational from current entries and ID/branch inputs, same cycle.
- fwd_a/fwd_b: combinational from registered entries only.
- Load-use costs exactly 1 stall cycle with FWD_EN, up to 2 without (3 if RF_BYPASS=0).
- Reset low at a rising edge: all entries invalid and stall_count=0 after that edge. While Reset is low, stall, bubble, flush_* = 0 and fwd_a=fwd_b=00 regardless of inputs.
- Reset asserted mid-stall or mid-flush: the sequence is abandoned; the first cycle after release has no hazards.

## Configuration

- HAZARD_FWD_EN defined: forwarding paths active; only load-use (and non-bypassed WB) hazards stall.
- HAZARD_FWD_EN undefined: fwd_a=fwd_b=00 constant, forwarding logic removed; every RAW hazard against EX/MEM (and WB if RF_BYPASS=0) stalls until the producer reaches WB.

## Test plan

- add $3,$1,$2 then sub $4,$3,$5 (FWD_EN): no stall; fwd_a=01 in sub's EX cycle, fwd_b=00.
- lw $3,0($1) then add $4,$3,$3 (FWD_EN): stall=bubble=1 for exactly 1 cycle, then fwd_a=fwd_b=10; stall_count=1.
- Same add/sub pair, FWD_EN undefined: stall held 2 cycles, fwd always 00, stall_count=2.
- Producers write $0, then a consumer reads $0: no stall, fwd 00.
- branch_taken asserted in the same cycle as a load-use stall: stall=0, all three flush_* =1; EX and MEM entries empty next cycle.
- stall_count driven to all-ones then further stalls: stays all-ones. Reset low for one edge mid-stall: all outputs 0/00 and count 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard control for the 5-stage pipeline: RAW stalls, EX operand forwarding (HAZARD_FWD_EN), branch flushes.
// Latency: stall/bubble/flush combinational from ID inputs and entries; fwd_a/fwd_b from registered entries.
// Backpressure: stall holds PC and IF/ID while bubble empties ID/EX; a taken branch overrides any stall.
module hazard_scoreboard #(
    parameter int REG_W       = 5,
    parameter bit RF_BYPASS   = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   id_valid,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [REG_W-1:0]       id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_is_load,
    input  logic                   branch_taken,
    output logic                   stall,
    output logic                   bubble,
    output logic                   flush_ifid,
    output logic                   flush_idex,
    output logic                   flush_exmem,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
    } entry_t;

    entry_t ex_q, mem_q, wb_q;
    logic   hit_ex, hit_wb, raw_hazard;

    function automatic logic writes(input entry_t e, input logic [REG_W-1:0] r);
        return e.valid && e.reg_write && (e.rd == r) && (r != '0);
    endfunction

    assign hit_ex = (id_uses_rs && writes(ex_q, id_rs)) || (id_uses_rt && writes(ex_q, id_rt));
    assign hit_wb = (id_uses_rs && writes(wb_q, id_rs)) || (id_uses_rt && writes(wb_q, id_rt));

`ifdef HAZARD_FWD_EN
    logic [REG_W-1:0] ex_rs_q, ex_rt_q;
    logic             ex_uses_rs_q, ex_uses_rt_q;
    logic             ex_load_q, mem_load_q;

    // Only a load still in EX cannot be forwarded in time.
    assign raw_hazard = (hit_ex && ex_load_q) || (!RF_BYPASS && hit_wb);
`else
    logic hit_mem;
    logic unused_load;

    assign unused_load = id_is_load;
    assign hit_mem     = (id_uses_rs && writes(mem_q, id_rs)) || (id_uses_rt && writes(mem_q, id_rt));
    assign raw_hazard  = hit_ex || hit_mem || (!RF_BYPASS && hit_wb);
`endif

    assign stall       = Reset && id_valid && !branch_taken && raw_hazard;
    assign bubble      = stall;
    assign flush_ifid  = Reset && branch_taken;
    assign flush_idex  = Reset && branch_taken;
    assign flush_exmem = Reset && branch_taken;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_count <= '0;
        end else begin
            if (stall && !(&stall_count)) begin
                stall_count <= stall_count + 1'b1;
            end
            wb_q <= mem_q;
            if (branch_taken) begin
                ex_q  <= '0;
                mem_q <= '0;
            end else begin
                mem_q <= ex_q;
                if (stall) begin
                    ex_q <= '0;
                end else begin
                    ex_q <= '{valid: id_valid, rd: id_rd, reg_write: id_reg_write};
                end
            end
        end
    end

`ifdef HAZARD_FWD_EN
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_uses_rs_q <= 1'b0;
            ex_uses_rt_q <= 1'b0;
            ex_load_q    <= 1'b0;
            mem_load_q   <= 1'b0;
        end else begin
            ex_rs_q      <= id_rs;
            ex_rt_q      <= id_rt;
            ex_uses_rs_q <= id_uses_rs;
            ex_uses_rt_q <= id_uses_rt;
            ex_load_q    <= !(branch_taken || stall) && id_valid && id_is_load;
            mem_load_q   <= !branch_taken && ex_load_q;
        end
    end

    // MEM result wins over WB: it is the younger producer.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (Reset && ex_q.valid) begin
            if (ex_uses_rs_q && writes(mem_q, ex_rs_q) && !mem_load_q) begin
                fwd_a = 2'b01;
            end else if (ex_uses_rs_q && writes(wb_q, ex_rs_q)) begin
                fwd_a = 2'b10;
            end
            if (ex_uses_rt_q && writes(mem_q, ex_rt_q) && !mem_load_q) begin
                fwd_b = 2'b01;
            end else if (ex_uses_rt_q && writes(wb_q, ex_rt_q)) begin
                fwd_b = 2'b10;
            end
        end
    end

    a_no_mem_load_into_ex: assert property (@(posedge Clk) disable iff (!Reset)
        !(ex_q.valid && mem_load_q &&
          ((ex_uses_rs_q && writes(mem_q, ex_rs_q)) || (ex_uses_rt_q && writes(mem_q, ex_rt_q)))));
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a per-cycle model built from instruction ages in the pipe.
module tb_hazard_scoreboard;
    localparam int RW  = 5;
    localparam bit BYP = 1'b1;
    localparam int CW  = 4;
    localparam logic [CW-1:0] CMAX = '1;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int RAW_ALU  = FWD ? 0 : 2;
    localparam int RAW_LOAD = FWD ? 1 : 2;

    logic          Clk, Reset, id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_is_load, branch_taken;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          stall, bubble, flush_ifid, flush_idex, flush_exmem;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.REG_W(RW), .RF_BYPASS(BYP), .STALL_CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .branch_taken(branch_taken),
        .stall(stall), .bubble(bubble), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exmem(flush_exmem), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model: every real instruction remembers the cycle it entered EX; its stage is its age.
    typedef struct {
        logic [RW-1:0] rs, rt, rd;
        bit            urs, urt, rw, ld;
        int            t_ex;
    } op_t;

    op_t           fl[$];
    int            cyc  = 0;
    logic [CW-1:0] mcnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {found, is_load} of an instruction at age stg that writes r.
    function automatic logic [1:0] who(input int stg, input logic [RW-1:0] r);
        foreach (fl[i]) begin
            if (cyc - fl[i].t_ex == stg && fl[i].rw && fl[i].rd == r && r != 0) return {1'b1, fl[i].ld};
        end
        return 2'b00;
    endfunction

    function automatic bit m_stall();
        logic [RW-1:0] src[2];
        bit            used[2];
        logic [1:0]    e, m, w;
        bit            h = 1'b0;
        if (Reset !== 1'b1 || branch_taken || !id_valid) return 1'b0;
        src[0] = id_rs; src[1] = id_rt;
        used[0] = id_uses_rs; used[1] = id_uses_rt;
        for (int k = 0; k < 2; k++) begin
            if (used[k]) begin
                e = who(0, src[k]); m = who(1, src[k]); w = who(2, src[k]);
                if (FWD ? (e == 2'b11) : (e[1] || m[1])) h = 1'b1;
                if (!BYP && w[1]) h = 1'b1;
            end
        end
        return h;
    endfunction

    function automatic logic [1:0] m_fwd(input bit use_rt);
        logic [1:0]    v = 2'b00;
        logic [1:0]    m, w;
        logic [RW-1:0] r;
        bit            u;
        if (Reset === 1'b1 && FWD) begin
            foreach (fl[i]) begin
                if (cyc == fl[i].t_ex) begin
                    u = use_rt ? fl[i].urt : fl[i].urs;
                    r = use_rt ? fl[i].rt : fl[i].rs;
                    m = who(1, r); w = who(2, r);
                    if (u && m == 2'b10) v = 2'b01;
                    else if (u && w[1]) v = 2'b10;
                end
            end
        end
        return v;
    endfunction

    always @(posedge Clk) begin : model
        bit s;
        s = m_stall();
        if (Reset !== 1'b1) begin
            fl.delete();
            mcnt = '0;
        end else begin
            if (s && mcnt != CMAX) mcnt = mcnt + 1'b1;
            for (int i = fl.size() - 1; i >= 0; i--) begin
                if (cyc - fl[i].t_ex >= 2 || (branch_taken && cyc - fl[i].t_ex <= 1)) fl.delete(i);
            end
            if (!branch_taken && !s && id_valid)
                fl.push_back('{rs: id_rs, rt: id_rt, rd: id_rd, urs: id_uses_rs, urt: id_uses_rt,
                               rw: id_reg_write, ld: id_is_load, t_ex: cyc + 1});
            cyc++;
        end
    end

    always @(negedge Clk) begin : compare
        bit s, f;
        s = m_stall();
        f = (Reset === 1'b1) && branch_taken;
        chk("stall", stall, s);
        chk("bubble", bubble, s);
        chk("flush_ifid", flush_ifid, f);
        chk("flush_idex", flush_idex, f);
        chk("flush_exmem", flush_exmem, f);
        chk("fwd_a", fwd_a, m_fwd(1'b0));
        chk("fwd_b", fwd_b, m_fwd(1'b1));
        chk("stall_count", stall_count, mcnt);
    end

    task automatic set_id(input logic [RW-1:0] rs, rt, input logic urs, urt,
                          input logic [RW-1:0] rd, input logic rw, ld);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_rd = rd; id_reg_write = rw; id_is_load = ld;
    endtask

    // Hold the instruction in ID until it enters EX; counts DUT stall cycles.
    task automatic issue(input logic [RW-1:0] rs, rt, input logic urs, urt,
                         input logic [RW-1:0] rd, input logic rw, ld, output int nst);
        bit s, done;
        done = 1'b0;
        nst  = 0;
        set_id(rs, rt, urs, urt, rd, rw, ld);
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            s = m_stall();
            if (stall === 1'b1) nst++;
            @(posedge Clk); #1;
            if (!s) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL issue_bound: instruction still held after 8 cycles, required entry into EX");
        end
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0; branch_taken = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge Clk); #1;
        Reset = 1'b0; branch_taken = 1'b1;
        set_id(3, 3, 1, 1, 3, 1, 1);
        @(negedge Clk);
        chk("rst_stall", stall, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_flush", {flush_ifid, flush_idex, flush_exmem}, 0);
        chk("rst_fwd", {fwd_a, fwd_b}, 0);
        @(posedge Clk); #1;
        Reset = 1'b1; id_valid = 1'b0; branch_taken = 1'b0;
        @(negedge Clk);
        chk("rst_count", stall_count, 0);
        @(posedge Clk); #1;
    endtask

    typedef struct {
        logic [RW-1:0] prd;
        bit            prw, pld;
        logic [RW-1:0] crs, crt;
        bit            curs, curt;
        int            st_nofwd, st_fwd;
    } vec_t;

    vec_t vt[5] = '{
        '{7, 1, 0, 9, 7, 1, 1, 2, 0},
        '{7, 1, 1, 9, 7, 1, 0, 0, 0},
        '{8, 1, 1, 8, 0, 1, 1, 2, 1},
        '{8, 0, 0, 8, 8, 1, 1, 0, 0},
        '{9, 1, 1, 2, 9, 0, 1, 2, 1}
    };

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        Reset = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0; branch_taken = 1'b0;

        // add $3,$1,$2 ; sub $4,$3,$5
        do_reset();
        issue(1, 2, 1, 1, 3, 1, 0, n);
        issue(3, 5, 1, 1, 4, 1, 0, n);
        chk("alu_raw_stalls", n, RAW_ALU);
        id_valid = 1'b0;
        @(negedge Clk);
        chk("alu_fwd_a", fwd_a, FWD ? 2'b01 : 2'b00);
        chk("alu_fwd_b", fwd_b, 2'b00);
        chk("alu_count", stall_count, RAW_ALU);
        @(posedge Clk); #1;
        idle(4);

        // lw $3,0($1) ; add $4,$3,$3
        do_reset();
        issue(1, 0, 1, 0, 3, 1, 1, n);
        issue(3, 3, 1, 1, 4, 1, 0, n);
        chk("lu_stalls", n, RAW_LOAD);
        id_valid = 1'b0;
        @(negedge Clk);
        chk("lu_fwd_a", fwd_a, FWD ? 2'b10 : 2'b00);
        chk("lu_fwd_b", fwd_b, FWD ? 2'b10 : 2'b00);
        chk("lu_count", stall_count, RAW_LOAD);
        @(posedge Clk); #1;
        idle(4);

        // writers of $0 never create hazards
        do_reset();
        issue(1, 2, 1, 1, 0, 1, 0, n);
        issue(1, 0, 1, 0, 0, 1, 1, n);
        issue(0, 0, 1, 1, 5, 1, 0, n);
        chk("r0_stalls", n, 0);
        id_valid = 1'b0;
        @(negedge Clk);
        chk("r0_fwd", {fwd_a, fwd_b}, 4'b0000);
        chk("r0_count", stall_count, 0);
        @(posedge Clk); #1;
        idle(4);

        // producer/consumer table: source selection, use flags, non-writers
        foreach (vt[i]) begin
            issue(1, 2, 1, 1, vt[i].prd, vt[i].prw, vt[i].pld, n);
            issue(vt[i].crs, vt[i].crt, vt[i].curs, vt[i].curt, 20, 1, 0, n);
            chk($sformatf("tbl%0d_stalls", i), n, FWD ? vt[i].st_fwd : vt[i].st_nofwd);
            idle(4);
        end

        // producer two ahead: load reaches WB as consumer enters EX
        do_reset();
        issue(1, 0, 1, 0, 6, 1, 1, n);
        issue(1, 2, 1, 1, 10, 1, 0, n);
        issue(6, 11, 1, 1, 12, 1, 0, n);
        chk("dist2_stalls", n, FWD ? 0 : 1);
        id_valid = 1'b0;
        @(negedge Clk);
        chk("dist2_fwd_a", fwd_a, FWD ? 2'b10 : 2'b00);
        chk("dist2_fwd_b", fwd_b, 2'b00);
        @(posedge Clk); #1;
        idle(4);

        // two writers of $3: MEM beats WB
        issue(1, 2, 1, 1, 3, 1, 0, n);
        issue(1, 2, 1, 1, 3, 1, 0, n);
        issue(2, 3, 1, 1, 13, 1, 0, n);
        chk("prio_stalls", n, RAW_ALU);
        id_valid = 1'b0;
        @(negedge Clk);
        chk("prio_fwd_a", fwd_a, 2'b00);
        chk("prio_fwd_b", fwd_b, FWD ? 2'b01 : 2'b00);
        @(posedge Clk); #1;
        idle(4);

        // branch taken during a load-use stall
        do_reset();
        issue(1, 0, 1, 0, 3, 1, 1, n);
        set_id(3, 3, 1, 1, 4, 1, 0);
        branch_taken = 1'b1;
        @(negedge Clk);
        chk("br_stall", stall, 0);
        chk("br_bubble", bubble, 0);
        chk("br_flushes", {flush_ifid, flush_idex, flush_exmem}, 3'b111);
        @(posedge Clk); #1;
        branch_taken = 1'b0;
        @(negedge Clk);
        chk("br_after_stall", stall, 0);
        chk("br_after_flush", {flush_ifid, flush_idex, flush_exmem}, 3'b000);
        @(posedge Clk); #1;
        idle(4);

        // saturate stall_count
        do_reset();
        repeat (20) begin
            issue(1, 0, 1, 0, 3, 1, 1, n);
            issue(3, 3, 1, 1, 4, 1, 0, n);
        end
        id_valid = 1'b0;
        @(negedge Clk);
        chk("sat_count", stall_count, CMAX);
        @(posedge Clk); #1;
        issue(1, 0, 1, 0, 3, 1, 1, n);
        issue(3, 3, 1, 1, 4, 1, 0, n);
        chk("sat_more_stalls", n, RAW_LOAD);
        id_valid = 1'b0;
        @(negedge Clk);
        chk("sat_hold", stall_count, CMAX);
        @(posedge Clk); #1;
        idle(4);

        // reset pulse in the middle of a load-use stall
        issue(1, 0, 1, 0, 3, 1, 1, n);
        set_id(3, 3, 1, 1, 4, 1, 0);
        @(negedge Clk);
        chk("mid_stall", stall, 1);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("mid_rst_stall", {stall, bubble}, 2'b00);
        chk("mid_rst_flush", {flush_ifid, flush_idex, flush_exmem}, 3'b000);
        chk("mid_rst_fwd", {fwd_a, fwd_b}, 4'b0000);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(negedge Clk);
        chk("mid_rst_count", stall_count, 0);
        chk("mid_rst_release", stall, 0);
        @(posedge Clk); #1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
